// File: rtl/image_feeder_pkg.sv
// rtl/image_feeder_pkg.sv - shared FSM encoding, size codes and image width lookup
package image_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [1:0] SIZE_4   = 2'b00;
  localparam logic [1:0] SIZE_8   = 2'b01;
  localparam logic [1:0] SIZE_16  = 2'b10;
  localparam logic [1:0] SIZE_16B = 2'b11;

  localparam int GAP_CYCLES_DEFAULT = 2;
  localparam int WIN_BITS           = 9;
  // memory read latency plus the pixel_in register
  localparam int PIPE_TAIL          = 2;

  function automatic logic [4:0] width_of(input logic [1:0] size);
    logic [4:0] w;
    w = 5'd16;
    case (size)
      SIZE_4:   w = 5'd4;
      SIZE_8:   w = 5'd8;
      SIZE_16:  w = 5'd16;
      SIZE_16B: w = 5'd16;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/image_feeder_if.sv
// rtl/image_feeder_if.sv - image memory bus and serial window stream
interface image_feeder_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data;
  logic              pixel_in;
  logic              start;
  logic              validData;
  logic [1:0]        filter;
  logic [ADDR_W-1:0] Pixel_address;

  modport master (
    output mem_rd, mem_addr, pixel_in, start, validData, filter, Pixel_address,
    input  mem_data
  );

  modport slave (
    input  mem_rd, mem_addr, pixel_in, start, validData, filter, Pixel_address,
    output mem_data
  );
endinterface

// File: rtl/image_feeder_window_addr_gen.sv
// rtl/image_feeder_window_addr_gen.sv - row-major address of bit k of the window at (row, col)
module window_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] i_row,
  input  logic [ADDR_W-1:0] i_col,
  input  logic [3:0]        i_k,
  input  logic [ADDR_W-1:0] i_w,
  output logic [ADDR_W-1:0] o_addr
);
  logic [1:0] w_dr;
  logic [1:0] w_dc;

  always_comb begin
    w_dr = 2'd0;
    w_dc = 2'd0;
    if (i_k >= 4'd6) begin
      w_dr = 2'd2;
      w_dc = 2'(i_k - 4'd6);
    end else if (i_k >= 4'd3) begin
      w_dr = 2'd1;
      w_dc = 2'(i_k - 4'd3);
    end else begin
      w_dc = i_k[1:0];
    end
  end

  assign o_addr = (i_row + ADDR_W'(w_dr)) * i_w + i_col + ADDR_W'(w_dc);

endmodule

// File: rtl/image_feeder.sv
// rtl/image_feeder.sv - streams every 3x3 window of a binary image bit-serially to a filter core
module image_feeder
  import image_feeder_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
  parameter int ADDR_W     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic [1:0]     size,
  input  logic [1:0]     filter_sel,
  output logic           busy,
  output logic           done,
  image_feeder_if.master bus
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_w;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic [3:0]        r_k;
  logic [15:0]       r_cnt;
  logic [1:0]        r_filter;

  logic              r_rd_d;
  logic [3:0]        r_k_d;
  logic [ADDR_W-1:0] r_addr_d;
  logic              r_pixel;
  logic              r_start;
  logic              r_valid;
  logic [ADDR_W-1:0] r_pix_addr;

  logic              w_rd;
  logic              w_busy;
  logic              w_done;
  logic              w_last_win;
  logic              w_fetch_end;
  logic              w_send_end;
  logic              w_gap_end;
  logic [ADDR_W-1:0] w_lim;
  logic [ADDR_W-1:0] w_addr;

  window_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .i_row  (r_row),
    .i_col  (r_col),
    .i_k    (r_k),
    .i_w    (r_w),
    .o_addr (w_addr)
  );

  assign w_lim       = r_w - ADDR_W'(3);
  assign w_last_win  = (r_row == w_lim) && (r_col == w_lim);
  assign w_fetch_end = (r_k == 4'(WIN_BITS - 1));
  assign w_send_end  = (r_cnt == 16'(PIPE_TAIL - 1));
  assign w_gap_end   = (r_cnt == 16'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (go) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_rd   = 1'b1;
        w_busy = 1'b1;
        if (w_fetch_end) w_next = ST_SEND;
      end
      ST_SEND: begin
        w_busy = 1'b1;
        if (w_send_end) begin
          if (w_last_win)           w_next = ST_DONE;
          else if (GAP_CYCLES == 0) w_next = ST_FETCH;
          else                      w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        w_busy = 1'b1;
        if (w_gap_end) w_next = ST_FETCH;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // window position advances only once its last bit has left the pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w      <= '0;
      r_filter <= 2'd0;
      r_row    <= '0;
      r_col    <= '0;
      r_k      <= 4'd0;
      r_cnt    <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_w      <= ADDR_W'(width_of(size));
            r_filter <= filter_sel;
            r_row    <= '0;
            r_col    <= '0;
            r_k      <= 4'd0;
            r_cnt    <= 16'd0;
          end
        end
        ST_FETCH: begin
          r_k   <= w_fetch_end ? 4'd0 : r_k + 4'd1;
          r_cnt <= 16'd0;
        end
        ST_SEND: begin
          r_cnt <= w_send_end ? 16'd0 : r_cnt + 16'd1;
          if (w_send_end && !w_last_win) begin
            if (r_col == w_lim) begin
              r_col <= '0;
              r_row <= r_row + ADDR_W'(1);
            end else begin
              r_col <= r_col + ADDR_W'(1);
            end
          end
        end
        ST_GAP: begin
          r_cnt <= w_gap_end ? 16'd0 : r_cnt + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_d     <= 1'b0;
      r_k_d      <= 4'd0;
      r_addr_d   <= '0;
      r_pixel    <= 1'b0;
      r_start    <= 1'b0;
      r_valid    <= 1'b0;
      r_pix_addr <= '0;
    end else begin
      r_rd_d   <= w_rd;
      r_k_d    <= r_k;
      r_addr_d <= w_addr;
      r_pixel  <= r_rd_d & bus.mem_data;
      r_start  <= r_rd_d;
      r_valid  <= r_rd_d && (r_k_d == 4'(WIN_BITS - 1));
      // bit 0 address is the window's top-left corner
      if (r_rd_d && (r_k_d == 4'd0)) r_pix_addr <= r_addr_d;
    end
  end

  assign bus.mem_rd        = w_rd;
  assign bus.mem_addr      = w_rd ? w_addr : '0;
  assign bus.pixel_in      = r_pixel;
  assign bus.start         = r_start;
  assign bus.validData     = r_valid;
  assign bus.filter        = r_filter;
  assign bus.Pixel_address = r_pix_addr;
  assign busy              = w_busy;
  assign done              = w_done;

endmodule

// File: tb/tb_image_feeder.sv
// tb/tb_image_feeder.sv - randomized bench for image_feeder against a window-schedule model
`timescale 1ns/1ps
module tb_image_feeder;
  localparam int GAP = 2;
  localparam int AW  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go;
  logic [1:0] size;
  logic [1:0] filter_sel;
  logic       busy;
  logic       done;

  image_feeder_if #(.ADDR_W(AW)) bus();

  image_feeder #(.GAP_CYCLES(GAP), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .size       (size),
    .filter_sel (filter_sel),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic img [256];
  int   cyc = 0;

  // synchronous image memory: data one cycle after the read strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.mem_data <= bus.mem_rd ? img[bus.mem_addr] : 1'($urandom_range(0, 1));
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endfunction

  // model state
  bit         m_seen_rst = 0;
  bit         m_active   = 0;
  bit         m_rst_prev = 0;
  int         m_go, m_w, m_n, m_p, m_done_off;
  logic [1:0] m_filter = 2'd0;
  logic [7:0] m_paddr  = 8'd0;

  int         o, j, n, k, r, c;
  bit         idle;
  logic       e_start, e_pix, e_valid, e_rd, e_busy, e_done;
  logic [7:0] e_addr, e_paddr;

  // observations used by the literal expectations
  int         mon_valid, mon_start, mon_ones, mon_done_cnt, mon_done_cyc;
  int         mon_max_addr, mon_first_rd_cyc, mon_first_rd_addr, mon_first_start_cyc;
  int         mon_bitcnt;
  logic [8:0] mon_bits;
  logic       mon_prev_start = 1'b0;
  int         mon_paddr_q[$];
  int         go_cyc;

  always @(negedge clk) begin
    if (m_seen_rst) begin
      e_start = 0; e_pix = 0; e_valid = 0; e_rd = 0; e_busy = 0; e_done = 0;
      e_addr = 8'd0; e_paddr = m_paddr;
      if (m_active) begin
        o = cyc - m_go;
        e_busy = (o >= 1) && (o < m_done_off);
        e_done = (o == m_done_off);
        if (o >= 3 && o < m_done_off) begin
          j = o - 3; n = j / m_p; k = j % m_p;
          if (k < 9) begin
            r = n / (m_w - 2); c = n % (m_w - 2);
            e_start = 1;
            e_pix   = img[(r + k / 3) * m_w + c + k % 3];
            e_valid = (k == 8);
            if (k == 0) e_paddr = 8'(r * m_w + c);
          end
        end
        if (o >= 1 && o < m_done_off) begin
          j = o - 1; n = j / m_p; k = j % m_p;
          if (k < 9 && n < m_n) begin
            r = n / (m_w - 2); c = n % (m_w - 2);
            e_rd   = 1;
            e_addr = 8'((r + k / 3) * m_w + c + k % 3);
          end
        end
        chk("mem_addr_range", 32'(int'(bus.mem_addr) < m_w * m_w), 32'd1);
      end
      chk("start", 32'(bus.start), 32'(e_start));
      if (e_start || m_rst_prev) chk("pixel_in", 32'(bus.pixel_in), 32'(e_pix));
      chk("validData", 32'(bus.validData), 32'(e_valid));
      chk("mem_rd", 32'(bus.mem_rd), 32'(e_rd));
      if (e_rd || m_rst_prev) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("Pixel_address", 32'(bus.Pixel_address), 32'(e_paddr));
      chk("filter", 32'(bus.filter), 32'(m_filter));
      m_paddr = e_paddr;

      if (bus.validData) mon_valid++;
      if (bus.start) begin
        mon_start++;
        if (bus.pixel_in) mon_ones++;
        if (mon_bitcnt < 9) begin
          mon_bits[mon_bitcnt] = bus.pixel_in;
          mon_bitcnt++;
        end
        if (mon_first_start_cyc < 0) mon_first_start_cyc = cyc;
        if (!mon_prev_start) mon_paddr_q.push_back(int'(bus.Pixel_address));
      end
      mon_prev_start = bus.start;
      if (bus.mem_rd) begin
        if (int'(bus.mem_addr) > mon_max_addr) mon_max_addr = int'(bus.mem_addr);
        if (mon_first_rd_cyc < 0) begin
          mon_first_rd_cyc  = cyc;
          mon_first_rd_addr = int'(bus.mem_addr);
        end
      end
      if (done) begin
        mon_done_cnt++;
        mon_done_cyc = cyc;
      end
    end

    if (!rst_n) begin
      m_seen_rst = 1; m_active = 0; m_paddr = 8'd0; m_filter = 2'd0; m_rst_prev = 1;
    end else if (m_seen_rst) begin
      m_rst_prev = 0;
      idle = !m_active || (cyc - m_go > m_done_off);
      if (idle && go) begin
        m_active   = 1;
        m_go       = cyc;
        m_w        = (size == 2'b00) ? 4 : (size == 2'b01) ? 8 : 16;
        m_filter   = filter_sel;
        m_n        = (m_w - 2) * (m_w - 2);
        m_p        = 11 + GAP;
        m_done_off = 3 + (m_n - 1) * m_p + 9;
      end
    end
  end

  task automatic clear_mon();
    mon_valid = 0; mon_start = 0; mon_ones = 0; mon_done_cnt = 0; mon_done_cyc = -1;
    mon_max_addr = -1; mon_first_rd_cyc = -1; mon_first_rd_addr = -1;
    mon_first_start_cyc = -1; mon_bitcnt = 0; mon_bits = 9'd0;
    mon_paddr_q.delete();
  endtask

  task automatic start_frame(input logic [1:0] sz, input logic [1:0] fs);
    @(posedge clk); #1;
    go = 1'b1; size = sz; filter_sel = fs; go_cyc = cyc;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int  base;
    bit  seen;
    base = mon_done_cnt;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (mon_done_cnt != base) seen = 1;
    end
    #1;
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) img[i] = 1'($urandom_range(0, 1));
  endtask

  logic [1:0] fs0;
  logic [1:0] rs;

  initial begin
    rst_n = 1'b0; go = 1'b0; size = 2'b00; filter_sel = 2'b00;
    for (int i = 0; i < 256; i++) img[i] = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {20'd0, bus.start, bus.validData, bus.pixel_in, bus.mem_rd, busy, done,
        bus.filter, bus.Pixel_address != 8'd0, bus.mem_addr != 8'd0, 2'd0}, 32'd0);
    rst_n = 1'b1;

    // 4x4 all ones
    for (int i = 0; i < 256; i++) img[i] = 1'b1;
    clear_mon();
    start_frame(2'b00, 2'b10);
    wait_done(200, "A_done_seen");
    chk("A_windows", 32'(mon_valid), 32'd4);
    chk("A_start_cycles", 32'(mon_start), 32'd36);
    chk("A_ones", 32'(mon_ones), 32'd36);
    chk("A_done_offset", 32'(mon_done_cyc - go_cyc), 32'd51);
    chk("A_filter", 32'(bus.filter), 32'd2);

    // 4x4 checkerboard-by-index
    for (int i = 0; i < 256; i++) img[i] = 1'(i % 2);
    clear_mon();
    start_frame(2'b00, 2'b01);
    wait_done(200, "B_done_seen");
    chk("B_win0_bits", 32'(mon_bits), 32'd146);
    chk("B_paddr_count", 32'(mon_paddr_q.size()), 32'd4);
    if (mon_paddr_q.size() == 4) begin
      chk("B_paddr0", 32'(mon_paddr_q[0]), 32'd0);
      chk("B_paddr1", 32'(mon_paddr_q[1]), 32'd1);
      chk("B_paddr2", 32'(mon_paddr_q[2]), 32'd4);
      chk("B_paddr3", 32'(mon_paddr_q[3]), 32'd5);
    end
    chk("B_rd_latency", 32'(mon_first_rd_cyc - go_cyc), 32'd1);
    chk("B_rd_addr", 32'(mon_first_rd_addr), 32'd0);
    chk("B_start_latency", 32'(mon_first_start_cyc - go_cyc), 32'd3);

    // 16x16 via size=11 with go and filter_sel disturbed mid-frame
    fill_random();
    clear_mon();
    fs0 = 2'b11;
    start_frame(2'b11, fs0);
    repeat (100) @(posedge clk);
    #1;
    go = 1'b1; filter_sel = 2'b00; size = 2'b00;
    @(posedge clk); #1;
    go = 1'b0; filter_sel = 2'b01;
    wait_done(3000, "C_done_seen");
    chk("C_windows", 32'(mon_valid), 32'd196);
    chk("C_last_paddr", 32'(mon_paddr_q[$]), 32'd221);
    chk("C_max_addr", 32'(mon_max_addr), 32'd255);
    chk("C_done_offset", 32'(mon_done_cyc - go_cyc), 32'd2547);
    chk("C_done_pulses", 32'(mon_done_cnt), 32'd1);
    chk("C_filter_held", 32'(bus.filter), 32'(fs0));

    // 8x8 aborted by reset during the second window, then restarted
    fill_random();
    clear_mon();
    start_frame(2'b01, 2'b10);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("D_after_reset", {21'd0, bus.start, bus.validData, bus.pixel_in, bus.mem_rd, busy, done,
        bus.filter, bus.Pixel_address != 8'd0, bus.mem_addr != 8'd0}, 32'd0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("D_no_done", 32'(mon_done_cnt), 32'd0);
    clear_mon();
    start_frame(2'b01, 2'b01);
    wait_done(800, "D_done_seen");
    chk("D_restart_paddr", 32'(mon_paddr_q[0]), 32'd0);
    chk("D_windows", 32'(mon_valid), 32'd36);

    // randomized frames with random spacing and ignored go pulses
    for (int f = 0; f < 4; f++) begin
      fill_random();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      rs = 2'($urandom_range(0, 3));
      start_frame(rs, 2'($urandom_range(0, 3)));
      repeat ($urandom_range(2, 40)) @(posedge clk);
      #1;
      go = 1'b1; filter_sel = 2'($urandom_range(0, 3)); size = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      go = 1'b0;
      wait_done(3000, "R_done_seen");
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
